// File: rtl/audio_stream_engine_if.sv
// Audio engine bus bundle: audio-port RAM signals plus the DAC and ADC SPI pins.
// master = the engine side, slave = the RAM / converter side.
interface audio_stream_engine_if;
   logic [14:0] ram_addr;
   logic        ram_en;
   logic [1:0]  ram_wr;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;
   logic        dac_sclk;
   logic        dac_cs;
   logic        dac_mosi;
   logic        adc_sclk;
   logic        adc_cs;
   logic        adc_miso;

   modport master (
      output ram_addr, ram_en, ram_wr, ram_wdata,
      input  ram_rdata,
      output dac_sclk, dac_cs, dac_mosi,
      output adc_sclk, adc_cs,
      input  adc_miso
   );

   modport slave (
      input  ram_addr, ram_en, ram_wr, ram_wdata,
      output ram_rdata,
      input  dac_sclk, dac_cs, dac_mosi,
      input  adc_sclk, adc_cs,
      output adc_miso
   );
endinterface

// File: rtl/audio_stream_engine.sv
// Sample-rate audio datapath: once per sample period fetch a playback word from the
// ring buffer, shift it to the DAC, capture an ADC word and write it back in place.
// Reports the free ring half via free_half / half_irq.
// Timing from the tick cycle T: FETCH T+1, WAIT T+2..T+3, DAC T+4..T+35, CS gap T+36,
// ADC T+37..T+68, write-back strobe in T+69 (committed by the RAM on the next edge).
module audio_stream_engine #(
   parameter int          CLOCKS_PER_SAMPLE = 600,
   parameter logic [15:0] BUF_FIRST         = 16'hC000,
   parameter logic [15:0] BUF_SECOND        = 16'hE000,
   parameter logic [15:0] BUF_LAST          = 16'hFFFE
) (
   input  logic                         system_clock,
   input  logic                         reset,
   input  logic                         enable,
   audio_stream_engine_if.master        bus,
   output logic                         free_half,
   output logic                         half_irq,
   input  logic                         irq_ack,
   output logic                         overrun
);
   localparam int CNT_W = (CLOCKS_PER_SAMPLE > 1) ? $clog2(CLOCKS_PER_SAMPLE) : 1;

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, DAC, GAP, ADC, WB} state_t;

   state_t            state_reg, state_next;
   logic [4:0]        step_reg;
   logic [CNT_W-1:0]  period_reg;
   logic              tick;
   logic [15:0]       ptr_reg;
   logic [15:0]       ptr_next;
   logic [15:0]       dac_shift_reg;
   logic [15:0]       adc_word_reg;
   logic              half_irq_reg;
   logic              overrun_reg;
   logic              half_set;
   logic              unused_bits;

   // Bits the datapath drops on purpose: low RAM bits of the playback word, the ADC
   // bits outside [11:4], and the always-zero byte bit of the word pointer.
   assign unused_bits = ^{bus.ram_rdata[5:0], adc_word_reg[15:12], adc_word_reg[3:0], ptr_reg[0]};

   assign tick      = enable && (period_reg == '0);
   assign ptr_next  = (ptr_reg == BUF_LAST) ? BUF_FIRST : ptr_reg + 16'd2;
   assign half_set  = (state_reg == WB) && ((ptr_next == BUF_SECOND) || (ptr_reg == BUF_LAST));
   assign free_half = (ptr_reg >= BUF_SECOND);
   assign half_irq  = half_irq_reg;
   assign overrun   = overrun_reg;

   // Sample period counter: free-runs while enabled, parked at 0 otherwise.
   always_ff @(posedge system_clock) begin
      if (reset || !enable) begin
         period_reg <= '0;
      end else if (period_reg == CNT_W'(CLOCKS_PER_SAMPLE - 1)) begin
         period_reg <= '0;
      end else begin
         period_reg <= period_reg + CNT_W'(1);
      end
   end

   // State register with a per-state step counter that restarts on every transition.
   always_ff @(posedge system_clock) begin
      if (reset) begin
         state_reg <= IDLE;
         step_reg  <= 5'd0;
      end else begin
         state_reg <= state_next;
         step_reg  <= (state_next != state_reg) ? 5'd0 : step_reg + 5'd1;
      end
   end

   // Next-state logic for one sample transaction.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (tick) state_next = FETCH;
         FETCH:   state_next = WAIT;
         WAIT:    if (step_reg == 5'd1) state_next = DAC;
         DAC:     if (step_reg == 5'd31) state_next = GAP;
         GAP:     state_next = ADC;
         ADC:     if (step_reg == 5'd31) state_next = WB;
         WB:      state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: pointer, serial shift registers and the sticky status flags.
   always_ff @(posedge system_clock) begin
      if (reset) begin
         ptr_reg       <= BUF_FIRST;
         dac_shift_reg <= 16'd0;
         adc_word_reg  <= 16'd0;
         half_irq_reg  <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         if (state_reg == WB) begin
            ptr_reg <= ptr_next;
         end
         // RAM data arrives two cycles after the fetch, i.e. in the second WAIT cycle.
         if (state_reg == WAIT && step_reg == 5'd1) begin
            dac_shift_reg <= {4'd0, bus.ram_rdata[15:6], 2'd0};
         end else if (state_reg == DAC && step_reg[0]) begin
            // Shift at the end of the sclk-high cycle so mosi only changes while sclk is low.
            dac_shift_reg <= {dac_shift_reg[14:0], 1'b0};
         end
         if (state_reg == ADC && step_reg[0]) begin
            adc_word_reg <= {adc_word_reg[14:0], bus.adc_miso};
         end
         if (half_set) begin
            half_irq_reg <= 1'b1;
         end else if (irq_ack) begin
            half_irq_reg <= 1'b0;
         end
         if (tick && state_reg != IDLE) begin
            overrun_reg <= 1'b1;
         end else if (irq_ack) begin
            overrun_reg <= 1'b0;
         end
      end
   end

   // Output decode: RAM port and SPI pins are driven purely from the current state.
   always_comb begin
      bus.ram_en    = 1'b0;
      bus.ram_wr    = 2'b00;
      bus.ram_addr  = 15'd0;
      bus.ram_wdata = 16'd0;
      bus.dac_cs    = 1'b1;
      bus.dac_sclk  = 1'b0;
      bus.dac_mosi  = 1'b0;
      bus.adc_cs    = 1'b1;
      bus.adc_sclk  = 1'b0;
      case (state_reg)
         FETCH: begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = ptr_reg[15:1];
         end
         DAC: begin
            bus.dac_cs   = 1'b0;
            bus.dac_sclk = step_reg[0];
            bus.dac_mosi = dac_shift_reg[15];
         end
         ADC: begin
            bus.adc_cs   = 1'b0;
            bus.adc_sclk = step_reg[0];
         end
         WB: begin
            bus.ram_en    = 1'b1;
            bus.ram_wr    = 2'b11;
            bus.ram_addr  = ptr_reg[15:1];
            bus.ram_wdata = {adc_word_reg[11:4], 8'h00};
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_audio_stream_engine.sv
// Bench for audio_stream_engine: a RAM and ADC device, a per-cycle reference model
// that predicts all outputs from the sample timeline, and directed scenarios.
module tb_audio_stream_engine;
   localparam int          CPS      = 80;
   localparam logic [15:0] B_FIRST  = 16'hC000;
   localparam logic [15:0] B_SECOND = 16'hC004;
   localparam logic [15:0] B_LAST   = 16'hC006;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset = 1'b1;
   logic enable = 1'b0;
   logic irq_ack = 1'b0;
   logic free_half, half_irq, overrun;
   logic enable2 = 1'b0;
   logic irq_ack2 = 1'b0;
   logic free_half2, half_irq2, overrun2;

   audio_stream_engine_if bus ();
   audio_stream_engine_if bus2 ();

   audio_stream_engine #(
      .CLOCKS_PER_SAMPLE(CPS), .BUF_FIRST(B_FIRST), .BUF_SECOND(B_SECOND), .BUF_LAST(B_LAST)
   ) dut (
      .system_clock(clk), .reset(reset), .enable(enable), .bus(bus),
      .free_half(free_half), .half_irq(half_irq), .irq_ack(irq_ack), .overrun(overrun)
   );

   // Short period, default ring: every other tick lands while busy.
   audio_stream_engine #(
      .CLOCKS_PER_SAMPLE(60)
   ) dut2 (
      .system_clock(clk), .reset(reset), .enable(enable2), .bus(bus2),
      .free_half(free_half2), .half_irq(half_irq2), .irq_ack(irq_ack2), .overrun(overrun2)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Audio RAM device: byte-strobed writes, reads return two cycles after ram_en.
   logic [15:0] mem [0:32767];
   logic [15:0] rd1;
   always @(posedge clk) begin
      if (bus.ram_en === 1'b1 && bus.ram_wr[1] === 1'b1) mem[bus.ram_addr][15:8] <= bus.ram_wdata[15:8];
      if (bus.ram_en === 1'b1 && bus.ram_wr[0] === 1'b1) mem[bus.ram_addr][7:0]  <= bus.ram_wdata[7:0];
      if (bus.ram_en === 1'b1 && bus.ram_wr === 2'b00) rd1 <= mem[bus.ram_addr];
      bus.ram_rdata <= rd1;
   end

   // ADC device: presents adc_val MSB first, advancing after each sclk-high cycle.
   logic [15:0] adc_val = 16'h0000;
   logic [3:0]  adc_idx = 4'd0;
   always @(posedge clk) begin
      if (bus.adc_cs !== 1'b0) adc_idx <= 4'd0;
      else if (bus.adc_sclk === 1'b1) adc_idx <= adc_idx + 4'd1;
   end
   assign bus.adc_miso = adc_val[4'd15 - adc_idx];

   assign bus2.ram_rdata = 16'h0000;
   assign bus2.adc_miso  = 1'b0;

   int          wr2_cnt = 0;
   logic [14:0] wr2_last = 15'd0;
   always @(negedge clk) begin
      if (bus2.ram_en === 1'b1 && bus2.ram_wr === 2'b11) begin
         wr2_cnt++;
         wr2_last = bus2.ram_addr;
      end
   end

   // Reference model: m_k is the cycle offset inside the current sample (tick = 0),
   // -1 when no sample is in flight.
   int          m_k = -1;
   int          m_phase = 0;
   logic [15:0] m_ptr = B_FIRST;
   logic [15:0] m_dac = 16'h0000;
   logic [15:0] m_adc = 16'h0000;
   logic        m_irq = 1'b0;
   logic        m_ovr = 1'b0;
   bit          chk_on = 1'b0;

   always @(negedge clk) begin
      logic [41:0] exp_v, act_v;
      logic        e_en, e_dcs, e_dsclk, e_mosi, e_acs, e_asclk;
      logic [1:0]  e_wr;
      logic [14:0] e_addr;
      logic [15:0] e_wdata;
      logic        busy, tick;
      int          bitn;
      if (m_k == 1) begin
         m_dac = {4'd0, mem[m_ptr[15:1]][15:6], 2'd0};
         m_adc = adc_val;
      end
      e_en    = (m_k == 1) || (m_k == 69);
      e_wr    = (m_k == 69) ? 2'b11 : 2'b00;
      e_addr  = e_en ? m_ptr[15:1] : 15'd0;
      e_wdata = (m_k == 69) ? {m_adc[11:4], 8'h00} : 16'h0000;
      e_dcs   = !(m_k >= 4 && m_k <= 35);
      e_dsclk = !e_dcs && ((m_k - 4) % 2 == 1);
      bitn    = 15 - (m_k - 4) / 2;
      e_mosi  = !e_dcs && m_dac[bitn[3:0]];
      e_acs   = !(m_k >= 37 && m_k <= 68);
      e_asclk = !e_acs && ((m_k - 37) % 2 == 1);
      exp_v = {e_en, e_wr, e_addr, e_wdata, e_dcs, e_dsclk, e_mosi, e_acs, e_asclk,
               (m_ptr >= B_SECOND), m_irq, m_ovr};
      act_v = {bus.ram_en, bus.ram_wr, bus.ram_addr, bus.ram_wdata, bus.dac_cs, bus.dac_sclk,
               bus.dac_mosi, bus.adc_cs, bus.adc_sclk, free_half, half_irq, overrun};
      if (chk_on) check("cycle", {22'd0, act_v}, {22'd0, exp_v});
      if (reset) begin
         m_k = -1; m_phase = 0; m_ptr = B_FIRST; m_irq = 1'b0; m_ovr = 1'b0;
      end else begin
         busy = (m_k >= 0);
         tick = enable && (m_phase == 0);
         if (irq_ack) begin m_irq = 1'b0; m_ovr = 1'b0; end
         if (m_k == 69) begin
            if (m_ptr == B_LAST) begin
               m_ptr = B_FIRST;
               m_irq = 1'b1;
            end else begin
               m_ptr = m_ptr + 16'd2;
               if (m_ptr == B_SECOND) m_irq = 1'b1;
            end
            m_k = -1;
         end else if (busy) begin
            m_k++;
         end
         if (tick) begin
            if (busy) m_ovr = 1'b1;
            else m_k = 1;
         end
         m_phase = enable ? (m_phase + 1) % CPS : 0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_wb(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (bus.ram_en === 1'b1 && bus.ram_wr === 2'b11) begin ok = 1'b1; break; end
      end
      if (!ok) check({name, " timeout"}, 64'd0, 64'd1);
   endtask

   task automatic dac_latency(input string name);
      int n = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         n++;
         if (bus.dac_cs === 1'b0) break;
      end
      check(name, 64'(n), 64'd4);
   endtask

   initial begin
      logic [15:0] w;
      for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
      mem[15'h6000] = 16'hFFC0;
      mem[15'h6001] = 16'h1234;
      mem[15'h6002] = 16'hA5C0;
      mem[15'h6003] = 16'h8040;
      adc_val = 16'h0AB0;

      repeat (3) @(posedge clk);
      #1;
      chk_on = 1'b1;
      check("reset outputs",
            {41'd0, bus.ram_en, bus.ram_wr, bus.ram_wdata, bus.dac_cs, bus.dac_sclk, bus.dac_mosi,
             bus.adc_cs, bus.adc_sclk, free_half, half_irq, overrun},
            {41'd0, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      reset = 1'b0;

      // Short period: overrun after the first sample, one write per two periods.
      enable2 = 1'b1;
      repeat (30) step();
      check("overrun2 before", 64'(overrun2), 64'd0);
      repeat (35) step();
      check("overrun2 after", 64'(overrun2), 64'd1);
      repeat (255) step();
      enable2 = 1'b0;
      check("dut2 write count", 64'(wr2_cnt), 64'd3);
      check("dut2 last addr", 64'(wr2_last), 64'h6002);

      // First sample: latency, DAC bit stream, write-back.
      enable = 1'b1;
      dac_latency("tick to dac_cs");
      w = 16'h0000;
      for (int i = 0; i < 32; i++) begin
         if (bus.dac_sclk === 1'b1) w = {w[14:0], bus.dac_mosi};
         step();
      end
      check("dac bits", 64'(w), 64'h0FFC);
      wait_wb("wb1");
      check("wb1 addr/data", {33'd0, bus.ram_addr, bus.ram_wdata}, {33'd0, 15'h6000, 16'hAB00});
      step();
      check("ram after wb1", 64'(mem[15'h6000]), 64'hAB00);
      check("flags after wb1", {61'd0, free_half, half_irq, overrun}, 64'd0);
      check("model ptr 1", 64'(m_ptr), 64'hC002);

      // Second sample crosses into the second half.
      adc_val = 16'h5A5A;
      wait_wb("wb2");
      check("wb2 addr/data", {33'd0, bus.ram_addr, bus.ram_wdata}, {33'd0, 15'h6001, 16'hA500});
      step();
      check("half crossing", {62'd0, free_half, half_irq}, 64'b11);
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      check("irq ack", {62'd0, free_half, half_irq}, 64'b10);

      // Third sample stays in the second half, fourth wraps with a colliding ack.
      adc_val = 16'h0FF0;
      wait_wb("wb3");
      check("wb3 addr/data", {33'd0, bus.ram_addr, bus.ram_wdata}, {33'd0, 15'h6002, 16'hFF00});
      step();
      check("no crossing", {62'd0, free_half, half_irq}, 64'b10);
      wait_wb("wb4");
      check("wb4 addr", 64'(bus.ram_addr), 64'h6003);
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      check("wrap set beats ack", {62'd0, free_half, half_irq}, 64'b01);
      check("model ptr wrap", 64'(m_ptr), 64'hC000);

      // Enable drops mid-sample: sample still completes, then everything idles.
      for (int i = 0; i < 100; i++) begin
         step();
         if (bus.dac_cs === 1'b0) break;
      end
      repeat (3) step();
      enable = 1'b0;
      wait_wb("wb disabled");
      check("wb disabled addr", 64'(bus.ram_addr), 64'h6000);
      repeat (150) step();
      enable = 1'b1;
      dac_latency("restart latency");

      // Reset in the middle of the DAC shift.
      repeat (6) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("reset abort pins",
            {59'd0, bus.dac_cs, bus.dac_sclk, bus.dac_mosi, bus.adc_cs, bus.ram_en}, 64'b10010);
      step();
      check("fetch after reset", {46'd0, bus.ram_en, bus.ram_wr, bus.ram_addr},
            {46'd0, 1'b1, 2'b00, 15'h6000});
      repeat (80) step();
      enable = 1'b0;
      repeat (5) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
